keypad_cmd_ctrl: RTL and testbench
==================================

Name: keypad_cmd_ctrl

Overview:
Sequencing front-end between the keypad scanner and the game state machine. It debounces press and release, and qualifies each press against the current game state. Each qualified press becomes exactly one command, delivered over a valid/ready handshake. Power-off needs a long PWRB hold, so a single tap cannot kill a game in progress.

Parameters:
DEBOUNCE_CYCLES, 540000, stable-press and stable-release qualification time in clk cycles (20 ms at 27 MHz); must be >= 2
LONGPRESS_CYCLES, 27000000, total PWRB hold time to issue PWR_OFF (1 s at 27 MHz); must be > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, 27 MHz
rst  input  1  synchronous, active-high reset
keypad_pressed  input  1  level, high while any key is down
key  input  5  key code, valid while keypad_pressed; 10=PWRB, 13=STB, 14=NO, 15=YES
presente  input  3  current game state: 0 OFF, 1 WLCM, 2 CH, 3 GAME, 4 WL, 5 PA
cmd_valid  output  1  command available
cmd_code  output  3  1 PWR_ON, 2 PWR_OFF, 3 START, 4 YES, 5 NO; 0 when cmd_valid=0
cmd_ready  input  1  consumer accepts the command this cycle
cmd_dropped  output  1  one-cycle pulse: debounced press was valid but not allowed in the current state
busy  output  1  high whenever the controller state is not IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; cnt=0; key_q=0; cmd_valid=0; cmd_code=0; cmd_dropped=0; busy=0. Reset mid-handshake discards any pending command.
- Counter cnt is 28 bits and saturates at LONGPRESS_CYCLES-1; it never wraps.
- States: IDLE, DEB, LONG, ISSUE, HELD.
- IDLE:
  - On an edge with keypad_pressed=1 (call it edge 0): latch key_q<=key, cnt<=0, go to DEB.
- DEB:
  - If keypad_pressed=0 or key!=key_q: go to IDLE. This is a glitch; no output.
  - Otherwise cnt<=cnt+1.
  - On the edge where cnt==DEBOUNCE_CYCLES-1 (edge D=DEBOUNCE_CYCLES), classify using presente sampled on that edge:
    - PWRB and presente==OFF: issue PWR_ON.
    - PWRB and presente!=OFF: go to LONG; cnt keeps counting.
    - STB and presente is WLCM or CH: issue START.
    - YES or NO and presente==PA: issue YES or NO.
    - Any other valid key (STB, YES, NO in a disallowed state): cmd_dropped=1 for that one cycle, go to HELD.
    - Any key code outside {10,13,14,15}: go to HELD silently.
- LONG:
  - If keypad_pressed=0 or key!=key_q: go to HELD. No command, no drop.
  - Otherwise cnt<=cnt+1; when cnt==LONGPRESS_CYCLES-1, issue PWR_OFF.
- "Issue" means: go to ISSUE, registered cmd_valid=1 and cmd_code set from the next cycle.
- Issue latency: cmd_valid rises D cycles after edge 0 for START/YES/NO/PWR_ON, and LONGPRESS_CYCLES cycles after edge 0 for PWR_OFF.
- ISSUE:
  - cmd_valid and cmd_code hold stable until an edge with cmd_ready=1. They are independent of key release and of changes on presente.
  - On that edge: cmd_valid<=0, cmd_code<=0, go to HELD.
  - If cmd_ready is never asserted, the controller waits indefinitely.
- HELD (release qualification):
  - On entry cnt<=0.
  - Each edge with keypad_pressed=0 does cnt+1; any edge with keypad_pressed=1 clears cnt to 0.
  - On the edge where cnt==DEBOUNCE_CYCLES-1 with keypad_pressed=0: go to IDLE.
- One press gives at most one command: no auto-repeat, and no second command while a key is held.
- A new press arriving during ISSUE or HELD is ignored until IDLE is reached.
- cmd_dropped and cmd_valid are never high in the same cycle.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=16, cmd_ready tied high unless stated.)
- STB pressed 10 cycles with presente=1 -> cmd_valid=1, cmd_code=3 exactly 4 cycles after edge 0, for one cycle; no further command; busy returns to 0 4 cycles after release.
- STB pressed 3 cycles, then released 1 cycle, then pressed 10 cycles, presente=2 -> the first burst yields nothing; a single START comes 4 cycles after the second press edge.
- PWRB held 20 cycles with presente=3 -> no command before edge 16; cmd_code=2 appears 16 cycles after edge 0. PWRB held only 8 cycles -> no command, no drop.
- PWRB pressed 6 cycles with presente=0 -> cmd_code=1 at cycle 4. YES pressed with presente=3 -> cmd_dropped pulses one cycle at cycle 4, cmd_valid stays 0.
- NO pressed with presente=5 and cmd_ready=0 for 7 cycles -> cmd_valid=1, cmd_code=5 held for 8 cycles, clearing the cycle after cmd_ready=1. Key release during the wait has no effect.
- rst=1 asserted while in ISSUE -> next cycle cmd_valid=0, cmd_code=0, busy=0. A key held through reset release is re-debounced from IDLE and yields one command 4 cycles after the first post-reset edge.

Source files
------------

// File: rtl/keypad_cmd_ctrl.sv
// Keypad press sequencer: debounces press/release, qualifies each press against game state, emits one command.
// Latency: command valid DEBOUNCE_CYCLES after press edge (PWR_OFF: LONGPRESS_CYCLES); dropped pulse at same point.
// Backpressure: command held stable in ISSUE until cmd_ready; no new press is accepted until release is debounced.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   keypad_pressed  - high while any key is down; key is the 5-bit code of that key
//   presente        - current game state (0 OFF, 1 WLCM, 2 CH, 3 GAME, 4 WL, 5 PA)
//   cmd_valid/cmd_code/cmd_ready - command handshake (1 PWR_ON, 2 PWR_OFF, 3 START, 4 YES, 5 NO)
//   cmd_dropped     - one-cycle pulse for a valid key not allowed in the current state
//   busy            - controller is not idle
module keypad_cmd_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 540000,
  parameter int unsigned LONGPRESS_CYCLES = 27000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keypad_pressed,
  input  logic [4:0] key,
  input  logic [2:0] presente,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic       cmd_dropped,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, DEB, LONG, ISSUE, HELD} state_t;

  localparam logic [27:0] DEB_LAST  = 28'(DEBOUNCE_CYCLES - 1);
  localparam logic [27:0] LONG_LAST = 28'(LONGPRESS_CYCLES - 1);

  localparam logic [4:0] KEY_PWRB = 5'd10;
  localparam logic [4:0] KEY_STB  = 5'd13;
  localparam logic [4:0] KEY_NO   = 5'd14;
  localparam logic [4:0] KEY_YES  = 5'd15;

  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_WLCM = 3'd1;
  localparam logic [2:0] ST_CH   = 3'd2;
  localparam logic [2:0] ST_PA   = 3'd5;

  localparam logic [2:0] CMD_PWR_ON  = 3'd1;
  localparam logic [2:0] CMD_PWR_OFF = 3'd2;
  localparam logic [2:0] CMD_START   = 3'd3;
  localparam logic [2:0] CMD_YES     = 3'd4;
  localparam logic [2:0] CMD_NO      = 3'd5;

  state_t      state_q;
  logic [27:0] cnt_q;
  logic [27:0] cnt_d;
  logic [4:0]  key_q;
  logic        cmd_valid_q;
  logic [2:0]  cmd_code_q;
  logic        cmd_dropped_q;

  // Saturating increment: the counter parks at LONGPRESS_CYCLES-1 instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != LONG_LAST) begin
      cnt_d = cnt_q + 28'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      cmd_dropped_q <= 1'b0;
    end else begin
      cmd_dropped_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (keypad_pressed) begin
            key_q   <= key;
            cnt_q   <= '0;
            state_q <= DEB;
          end
        end

        DEB: begin
          if (!keypad_pressed || key != key_q) begin
            state_q <= IDLE;                  // glitch, discard silently
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q == DEB_LAST) begin
              // Default outcome is a silent move to HELD; issue/drop cases override it.
              state_q <= HELD;
              cnt_q   <= '0;
              case (key_q)
                KEY_PWRB: begin
                  if (presente == ST_OFF) begin
                    state_q     <= ISSUE;
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= CMD_PWR_ON;
                  end else begin
                    state_q <= LONG;          // keep counting toward the long hold
                    cnt_q   <= cnt_d;
                  end
                end
                KEY_STB: begin
                  if (presente == ST_WLCM || presente == ST_CH) begin
                    state_q     <= ISSUE;
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= CMD_START;
                  end else begin
                    cmd_dropped_q <= 1'b1;
                  end
                end
                KEY_YES, KEY_NO: begin
                  if (presente == ST_PA) begin
                    state_q     <= ISSUE;
                    cmd_valid_q <= 1'b1;
                    cmd_code_q  <= (key_q == KEY_YES) ? CMD_YES : CMD_NO;
                  end else begin
                    cmd_dropped_q <= 1'b1;
                  end
                end
                default: ;                    // unknown code: HELD, no output
              endcase
            end
          end
        end

        LONG: begin
          if (!keypad_pressed || key != key_q) begin
            state_q <= HELD;                  // short PWRB tap in a game: ignored
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q == LONG_LAST) begin
              state_q     <= ISSUE;
              cmd_valid_q <= 1'b1;
              cmd_code_q  <= CMD_PWR_OFF;
            end
          end
        end

        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            state_q     <= HELD;
            cnt_q       <= '0;
          end
        end

        HELD: begin
          // Require DEBOUNCE_CYCLES consecutive released samples before re-arming.
          if (keypad_pressed) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_dropped = cmd_dropped_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_cmd_ctrl.sv
// Directed bench for keypad_cmd_ctrl with DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=16.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Each check compares {cmd_valid, cmd_code, cmd_dropped, busy} against hand-derived values.
module tb_keypad_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       keypad_pressed;
  logic [4:0] key;
  logic [2:0] presente;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic       cmd_dropped;
  logic       busy;

  int total = 0;
  int bad   = 0;

  keypad_cmd_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .LONGPRESS_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .keypad_pressed(keypad_pressed),
    .key           (key),
    .presente      (presente),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_ready     (cmd_ready),
    .cmd_dropped   (cmd_dropped),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ev(input logic v, input logic [2:0] c, input logic d, input logic b);
    return {v, c, d, b};
  endfunction

  // Advance one rising edge, then compare the outputs produced by that edge.
  task automatic step_chk(input string tag, input int idx, input logic [5:0] exp);
    logic [5:0] obs;
    @(posedge clk);
    #1;
    obs = {cmd_valid, cmd_code, cmd_dropped, busy};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed v/code/drop/busy=%b required=%b", tag, idx, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    keypad_pressed = 1'b0;
    key            = 5'd0;
    presente       = 3'd0;
    cmd_ready      = 1'b1;

    // Reset state
    step_chk("reset", 0, ev(1'b0, 3'd0, 1'b0, 1'b0));
    step_chk("reset", 1, ev(1'b0, 3'd0, 1'b0, 1'b0));
    rst = 1'b0;
    step_chk("idle", 0, ev(1'b0, 3'd0, 1'b0, 1'b0));

    // STB in WLCM, 10-cycle press: START after edge 4, release debounced at edge 13
    presente = 3'd1; key = 5'd13;
    for (int i = 0; i < 14; i++) begin
      keypad_pressed = (i < 10);
      step_chk("stb_wlcm", i, ev(i == 4, (i == 4) ? 3'd3 : 3'd0, 1'b0, i < 13));
    end

    // STB in CH: 3-cycle glitch, 1-cycle gap, then 10-cycle press from edge 4
    presente = 3'd2;
    for (int i = 0; i < 18; i++) begin
      keypad_pressed = (i < 3) || (i >= 4 && i < 14);
      step_chk("stb_glitch", i, ev(i == 8, (i == 8) ? 3'd3 : 3'd0, 1'b0, (i != 3) && (i < 17)));
    end

    // PWRB in GAME held 20 cycles: PWR_OFF after edge 16
    presente = 3'd3; key = 5'd10;
    for (int i = 0; i < 24; i++) begin
      keypad_pressed = (i < 20);
      step_chk("pwr_long", i, ev(i == 16, (i == 16) ? 3'd2 : 3'd0, 1'b0, i < 23));
    end

    // PWRB in GAME held only 8 cycles: nothing issued, nothing dropped
    for (int i = 0; i < 13; i++) begin
      keypad_pressed = (i < 8);
      step_chk("pwr_short", i, ev(1'b0, 3'd0, 1'b0, i < 12));
    end

    // PWRB in OFF, 6-cycle press: PWR_ON after edge 4
    presente = 3'd0;
    for (int i = 0; i < 10; i++) begin
      keypad_pressed = (i < 6);
      step_chk("pwr_on", i, ev(i == 4, (i == 4) ? 3'd1 : 3'd0, 1'b0, i < 9));
    end

    // YES in GAME: dropped pulse after edge 4, no command
    presente = 3'd3; key = 5'd15;
    for (int i = 0; i < 10; i++) begin
      keypad_pressed = (i < 6);
      step_chk("yes_drop", i, ev(1'b0, 3'd0, i == 4, i < 9));
    end

    // NO in PA with consumer stalled: held edges 4..11, ready at edge 12, key released at edge 6
    presente = 3'd5; key = 5'd14; cmd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      keypad_pressed = (i < 6);
      cmd_ready      = (i >= 12);
      step_chk("no_stall", i, ev(i >= 4 && i <= 11, (i >= 4 && i <= 11) ? 3'd5 : 3'd0, 1'b0, i < 16));
    end

    // Reset while a START waits in ISSUE; key held through reset is re-debounced
    presente = 3'd1; key = 5'd13; cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      keypad_pressed = 1'b1;
      step_chk("rst_pre", i, ev(i == 4, (i == 4) ? 3'd3 : 3'd0, 1'b0, 1'b1));
    end
    rst = 1'b1;
    step_chk("rst_issue", 0, ev(1'b0, 3'd0, 1'b0, 1'b0));
    rst = 1'b0; cmd_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      keypad_pressed = (i < 10);
      step_chk("rst_post", i, ev(i == 4, (i == 4) ? 3'd3 : 3'd0, 1'b0, i < 13));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
